// File: rtl/serialcmd_pkg.sv
// rtl/serialcmd_pkg.sv - shared stream scheduler constants and state encoding
package serialcmd_pkg;

  localparam int SRC_RESP = 0;   // response stream source index
  localparam int ID_W     = 4;   // stream id width
  localparam int WORD_W   = 32;  // stream word width
  localparam int CNT_W    = 8;   // message word count width

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } sched_state_t;

endpackage

// File: rtl/txstream_sched_rr_pick.sv
// rtl/txstream_sched_rr_pick.sv - rotating-priority finder over sample sources
//
// elig   : eligibility of sample sources 1..NUM_SRC-1
// rr_ptr : first source to consider (1..NUM_SRC-1)
// found  : some sample source is eligible
// idx    : first eligible source at or after rr_ptr, wrapping NUM_SRC-1 -> 1
module rr_pick
  import serialcmd_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:1] elig,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  // First pass covers rr_ptr..top; the second pass, which only fires when
  // the first found nothing, naturally yields the lowest source below rr_ptr.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (!found && elig[i] && (i >= int'(rr_ptr))) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
    for (int i = 1; i < NUM_SRC; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/txstream_sched.sv
// rtl/txstream_sched.sv - whole-message scheduler sharing the encoder stream input
//
// clk, rst_n            : clock, synchronous active-low reset
// src_data/src_count    : per-source current word and pending message length
// src_avail/src_enable  : per-source word valid and scheduling enable
// src_pull              : per-source pop strobe (combinational)
// strm_data/strm_avail  : granted word and its valid towards the encoder
// strm_count/strm_id    : latched message length and granted source index
// strm_pull             : encoder pops one word
// busy/msg_done         : message in progress / last word popped this cycle
module txstream_sched
  import serialcmd_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int RESP_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*WORD_W-1:0] src_data,
  input  logic [NUM_SRC*CNT_W-1:0]  src_count,
  input  logic [NUM_SRC-1:0]        src_avail,
  output logic [NUM_SRC-1:0]        src_pull,
  input  logic [NUM_SRC-1:0]        src_enable,
  output logic [WORD_W-1:0]         strm_data,
  output logic [CNT_W-1:0]          strm_count,
  output logic [ID_W-1:0]           strm_id,
  output logic                      strm_avail,
  input  logic                      strm_pull,
  output logic                      busy,
  output logic                      msg_done
);

  localparam int              RUN_W    = $clog2(RESP_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RESP_LIMIT);
  localparam logic [ID_W-1:0]  LAST_SRC = ID_W'(NUM_SRC - 1);
  localparam logic [ID_W-1:0]  RESP_ID  = ID_W'(SRC_RESP);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   gnt_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  count_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [RUN_W-1:0]  resp_run_q;

  logic [NUM_SRC-1:0] elig;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic               resp_wins;
  logic               any_elig;
  logic [ID_W-1:0]    win_id;
  logic [CNT_W-1:0]   win_count;
  logic               gnt_avail;
  logic [WORD_W-1:0]  gnt_data;
  logic               pull_ok;
  logic               last_word;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = src_avail[i] && src_enable[i] &&
                (src_count[CNT_W*i +: CNT_W] != '0);
    end
  end

  rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
    .elig   (elig[NUM_SRC-1:1]),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Responses win unless they have used up their run while a sample waits.
  always_comb begin
    resp_wins = elig[SRC_RESP] && ((resp_run_q < RUN_MAX) || !pick_found);
    any_elig  = elig[SRC_RESP] || pick_found;
    win_id    = resp_wins ? RESP_ID : pick_idx;
    win_count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_id == ID_W'(i)) win_count = src_count[CNT_W*i +: CNT_W];
    end
  end

  always_comb begin
    gnt_avail = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_q == ID_W'(i)) begin
        gnt_avail = src_avail[i];
        gnt_data  = src_data[WORD_W*i +: WORD_W];
      end
    end
  end

  assign busy      = (state_q == ST_XFER);
  assign pull_ok   = busy && strm_pull && gnt_avail;
  assign last_word = pull_ok && (remaining_q == CNT_W'(1));

  always_comb begin
    src_pull = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pull_ok && (gnt_q == ID_W'(i))) src_pull[i] = 1'b1;
    end
  end

  assign strm_avail = busy && gnt_avail;
  assign strm_data  = busy ? gnt_data : '0;
  assign strm_id    = busy ? gnt_q : '0;
  assign strm_count = count_q;
  assign msg_done   = last_word;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_elig) state_d = ST_XFER;
      ST_XFER: if (last_word) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      rr_ptr_q    <= ID_W'(1);
      resp_run_q  <= '0;
    end else if ((state_q == ST_IDLE) && any_elig) begin
      gnt_q       <= win_id;
      remaining_q <= win_count;
      count_q     <= win_count;
      if (resp_wins) begin
        resp_run_q <= (resp_run_q == RUN_MAX) ? RUN_MAX : resp_run_q + 1'b1;
      end else begin
        resp_run_q <= '0;
        rr_ptr_q   <= (pick_idx == LAST_SRC) ? ID_W'(1) : pick_idx + 1'b1;
      end
    end else if (pull_ok) begin
      remaining_q <= remaining_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_txstream_sched.sv
// tb/tb_txstream_sched.sv - self-checking bench for txstream_sched
module tb_txstream_sched;

  localparam int NS = 4;
  localparam int RL = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS*32-1:0] src_data;
  logic [NS*8-1:0]  src_count;
  logic [NS-1:0]    src_avail;
  logic [NS-1:0]    src_pull;
  logic [NS-1:0]    src_enable;
  logic [31:0]      strm_data;
  logic [7:0]       strm_count;
  logic [3:0]       strm_id;
  logic             strm_avail;
  logic             strm_pull;
  logic             busy;
  logic             msg_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  txstream_sched #(.NUM_SRC(NS), .RESP_LIMIT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_data(src_data), .src_count(src_count), .src_avail(src_avail),
    .src_pull(src_pull), .src_enable(src_enable),
    .strm_data(strm_data), .strm_count(strm_count), .strm_id(strm_id),
    .strm_avail(strm_avail), .strm_pull(strm_pull),
    .busy(busy), .msg_done(msg_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_avail = '0; src_enable = '0; src_count = '0; src_data = '0; strm_pull = 1'b0;
  endtask

  task automatic set_src(input int i, input logic av, input logic en, input int cnt);
    src_avail[i] = av;
    src_enable[i] = en;
    src_count[8*i +: 8] = 8'(cnt);
    src_data[32*i +: 32] = $urandom();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic bit elig_m(input int s);
    return src_avail[s] && src_enable[s] && (src_count[8*s +: 8] != 8'd0);
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 1'b1, 2);
    strm_pull = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (src_pull !== 4'b0) begin errors++; $display("FAIL reset_src_pull: got %b expected 0000", src_pull); end
    checks++; if (strm_avail !== 1'b0 || busy !== 1'b0 || msg_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got avail=%b busy=%b done=%b expected 0 0 0", strm_avail, busy, msg_done); end
    checks++; if (strm_id !== 4'd0 || strm_count !== 8'd0 || strm_data !== 32'd0) begin
      errors++; $display("FAIL reset_values: got id=%0d cnt=%0d data=%h expected 0 0 0", strm_id, strm_count, strm_data); end
  endtask

  task automatic test_single();
    logic [31:0] exp_d;
    do_reset();
    strm_pull = 1'b1;
    set_src(0, 1'b1, 1'b1, 3);
    @(negedge clk);
    checks++; if (strm_avail !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_arb_cycle: got avail=%b busy=%b expected 0 0", strm_avail, busy); end
    tick();
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      exp_d = src_data[31:0];
      checks++; if (src_pull !== 4'b0001 || strm_avail !== 1'b1) begin
        errors++; $display("FAIL single_pull w%0d: got pull=%b avail=%b expected 0001 1", w, src_pull, strm_avail); end
      checks++; if (strm_id !== 4'd0 || strm_count !== 8'd3 || strm_data !== exp_d) begin
        errors++; $display("FAIL single_word w%0d: got id=%0d cnt=%0d data=%h expected 0 3 %h", w, strm_id, strm_count, strm_data, exp_d); end
      checks++; if (msg_done !== (w == 2)) begin
        errors++; $display("FAIL single_done w%0d: got %b expected %b", w, msg_done, (w == 2)); end
      tick();
      src_data[31:0] = $urandom();
    end
    src_avail[0] = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || msg_done !== 1'b0) begin
      errors++; $display("FAIL single_after: got busy=%b done=%b expected 0 0", busy, msg_done); end
  endtask

  task automatic test_round_robin();
    do_reset();
    strm_pull = 1'b1;
    for (int i = 1; i < NS; i++) set_src(i, 1'b1, 1'b1, 1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if (busy !== (c % 2 == 1)) begin
        errors++; $display("FAIL rr_busy c%0d: got %b expected %b", c, busy, (c % 2 == 1)); end
      if (c % 2 == 1) begin
        checks++; if (int'(strm_id) != 1 + ((c / 2) % 3) || msg_done !== 1'b1) begin
          errors++; $display("FAIL rr_id c%0d: got id=%0d done=%b expected %0d 1", c, strm_id, msg_done, 1 + ((c / 2) % 3)); end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    int ids[$];
    int exp_ids[8] = '{0, 0, 0, 2, 0, 0, 0, 2};
    logic prev = 1'b0;
    int cyc = 0;
    do_reset();
    strm_pull = 1'b1;
    set_src(0, 1'b1, 1'b1, 2);
    set_src(2, 1'b1, 1'b1, 2);
    while (ids.size() < 8 && cyc < 80) begin
      @(negedge clk);
      if (busy && !prev) ids.push_back(int'(strm_id));
      prev = busy;
      tick();
      cyc++;
    end
    checks++; if (ids.size() != 8) begin
      errors++; $display("FAIL starve_timeout: got %0d grants expected 8", ids.size()); end
    for (int k = 0; k < ids.size(); k++) begin
      checks++; if (ids[k] != exp_ids[k]) begin
        errors++; $display("FAIL starve_order k%0d: got %0d expected %0d", k, ids[k], exp_ids[k]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    strm_pull = 1'b1;
    set_src(1, 1'b1, 1'b1, 4);
    tick();
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      checks++; if (src_pull !== 4'b0010 || strm_id !== 4'd1) begin
        errors++; $display("FAIL stall_pre w%0d: got pull=%b id=%0d expected 0010 1", w, src_pull, strm_id); end
      tick();
    end
    src_avail[1] = 1'b0;
    set_src(0, 1'b1, 1'b1, 1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (strm_avail !== 1'b0 || src_pull !== 4'b0 || busy !== 1'b1 || strm_id !== 4'd1) begin
        errors++; $display("FAIL stall_hold s%0d: got avail=%b pull=%b busy=%b id=%0d expected 0 0000 1 1", s, strm_avail, src_pull, busy, strm_id); end
      tick();
    end
    src_avail[1] = 1'b1;
    for (int w = 2; w < 4; w++) begin
      @(negedge clk);
      checks++; if (src_pull !== 4'b0010 || msg_done !== (w == 3)) begin
        errors++; $display("FAIL stall_resume w%0d: got pull=%b done=%b expected 0010 %b", w, src_pull, msg_done, (w == 3)); end
      tick();
    end
    src_avail[1] = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_gap: got busy=%b expected 0", busy); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || strm_id !== 4'd0) begin
      errors++; $display("FAIL stall_next: got busy=%b id=%0d expected 1 0", busy, strm_id); end
  endtask

  task automatic test_boundaries();
    int pulls = 0;
    int done_at = -1;
    logic [7:0] cnt_at = '0;
    // zero-count message is never granted
    do_reset();
    strm_pull = 1'b1;
    set_src(2, 1'b1, 1'b1, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || src_pull !== 4'b0) begin
        errors++; $display("FAIL zero_count c%0d: got busy=%b pull=%b expected 0 0000", c, busy, src_pull); end
      tick();
    end
    // maximum count
    do_reset();
    strm_pull = 1'b1;
    set_src(1, 1'b1, 1'b1, 255);
    for (int c = 0; c < 600 && done_at < 0; c++) begin
      @(negedge clk);
      if (src_pull[1]) pulls++;
      if (msg_done) begin done_at = pulls; cnt_at = strm_count; end
      tick();
    end
    checks++; if (done_at != 255) begin errors++; $display("FAIL count255_pulls: got %0d expected 255", done_at); end
    checks++; if (cnt_at !== 8'd255) begin errors++; $display("FAIL count255_latched: got %0d expected 255", cnt_at); end
    // disable mid-message
    do_reset();
    strm_pull = 1'b1;
    set_src(3, 1'b1, 1'b1, 3);
    tick();
    src_enable[3] = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      checks++; if (src_pull !== 4'b1000 || msg_done !== (w == 2)) begin
        errors++; $display("FAIL disable_mid w%0d: got pull=%b done=%b expected 1000 %b", w, src_pull, msg_done, (w == 2)); end
      tick();
    end
    set_src(1, 1'b1, 1'b1, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        checks++; if (busy !== 1'b1 || strm_id !== 4'd1) begin
          errors++; $display("FAIL disable_skip c%0d: got busy=%b id=%0d expected 1 1", c, busy, strm_id); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    strm_pull = 1'b1;
    set_src(1, 1'b1, 1'b1, 5);
    set_src(2, 1'b1, 1'b1, 5);
    tick();
    @(negedge clk);
    checks++; if (strm_id !== 4'd1) begin errors++; $display("FAIL rstmid_first: got %0d expected 1", strm_id); end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (strm_avail !== 1'b0 || busy !== 1'b0 || src_pull !== 4'b0 || msg_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got avail=%b busy=%b pull=%b done=%b expected 0 0 0000 0", strm_avail, busy, src_pull, msg_done); end
    checks++; if (strm_count !== 8'd0 || strm_id !== 4'd0) begin
      errors++; $display("FAIL rstmid_values: got cnt=%0d id=%0d expected 0 0", strm_count, strm_id); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || strm_id !== 4'd1 || strm_count !== 8'd5) begin
      errors++; $display("FAIL rstmid_rearb: got busy=%b id=%0d cnt=%0d expected 1 1 5", busy, strm_id, strm_count); end
  endtask

  task automatic test_random();
    int m_busy, m_gnt, m_left, m_cnt, m_rr, m_streak;
    logic [NS-1:0] e_pull;
    logic e_avail, e_done;
    logic [31:0] e_data;
    int e_id;
    do_reset();
    m_busy = 0; m_gnt = 0; m_left = 0; m_cnt = 0; m_rr = 1; m_streak = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NS; i++) begin
        src_avail[i] = ($urandom_range(0, 3) != 0);
        src_enable[i] = ($urandom_range(0, 7) != 0);
        src_count[8*i +: 8] = 8'($urandom_range(0, 4));
        src_data[32*i +: 32] = $urandom();
      end
      strm_pull = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e_pull = '0;
      e_avail = m_busy != 0 && src_avail[m_gnt];
      e_data = (m_busy != 0) ? src_data[32*m_gnt +: 32] : 32'd0;
      e_id = (m_busy != 0) ? m_gnt : 0;
      if (e_avail && strm_pull) e_pull[m_gnt] = 1'b1;
      e_done = (e_pull != '0) && m_left == 1;
      checks++; if (src_pull !== e_pull) begin
        errors++; $display("FAIL rnd_pull cyc%0d: got %b expected %b", cyc, src_pull, e_pull); end
      checks++; if ({strm_avail, busy, msg_done} !== {e_avail, (m_busy != 0), e_done}) begin
        errors++; $display("FAIL rnd_flags cyc%0d: got %b%b%b expected %b%b%b", cyc, strm_avail, busy, msg_done, e_avail, (m_busy != 0), e_done); end
      checks++; if (strm_id !== 4'(e_id) || strm_count !== 8'(m_cnt)) begin
        errors++; $display("FAIL rnd_id cyc%0d: got id=%0d cnt=%0d expected %0d %0d", cyc, strm_id, strm_count, e_id, m_cnt); end
      checks++; if (strm_data !== e_data) begin
        errors++; $display("FAIL rnd_data cyc%0d: got %h expected %h", cyc, strm_data, e_data); end
      if (!rst_n) begin
        m_busy = 0; m_gnt = 0; m_left = 0; m_cnt = 0; m_rr = 1; m_streak = 0;
      end else if (m_busy != 0) begin
        if (e_pull != '0) begin
          m_left--;
          if (m_left == 0) m_busy = 0;
        end
      end else begin
        int win = -1;
        bit samp_any = 0;
        for (int s = 1; s < NS; s++) if (elig_m(s)) samp_any = 1;
        if (elig_m(0) && (m_streak < RL || !samp_any)) win = 0;
        else begin
          for (int off = 0; off < NS - 1 && win < 0; off++) begin
            int s = 1 + (m_rr - 1 + off) % (NS - 1);
            if (elig_m(s)) win = s;
          end
        end
        if (win >= 0) begin
          m_busy = 1; m_gnt = win;
          m_left = int'(src_count[8*win +: 8]);
          m_cnt = m_left;
          if (win == 0) m_streak = (m_streak < RL) ? m_streak + 1 : RL;
          else begin m_streak = 0; m_rr = win % (NS - 1) + 1; end
        end
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_stall();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
